// File: rtl/adsr_pkg.sv
// Shared constants for the voice allocator: FSM encodings, voice count and ADSR presets.
// Preset words are packed {attack, decay, sustain, released}, 8 bits each.
package adsr_pkg;
  localparam int NUM_VOICES = 4;
  localparam int NOTE_W     = 7;
  localparam int ADSR_W     = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KILL  = 2'd1,
    S_START = 2'd2
  } state_t;

  localparam logic [ADSR_W-1:0] PRESET_CALM  = 32'h0402_C002;
  localparam logic [ADSR_W-1:0] PRESET_HAPPY = 32'h4010_8040;
  localparam logic [ADSR_W-1:0] PRESET_SAD   = 32'h0201_6001;
  localparam logic [ADSR_W-1:0] PRESET_ANGRY = 32'hFF40_A040;

  function automatic logic [ADSR_W-1:0] preset_lookup(input logic [1:0] emotion);
    logic [ADSR_W-1:0] p;
    case (emotion)
      2'd0:    p = PRESET_CALM;
      2'd1:    p = PRESET_HAPPY;
      2'd2:    p = PRESET_SAD;
      default: p = PRESET_ANGRY;
    endcase
    return p;
  endfunction
endpackage

// File: rtl/dffre.sv
// Generic register with synchronous active-high reset and load enable.
// One cycle latency from d_i to q_o; no flow control.
module dffre #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk) begin
    if (reset)     q_o <= RST_VAL;
    else if (en_i) q_o <= d_i;
  end
endmodule

// File: rtl/lru_tracker.sv
// LRU ranking of voices (rank 0 = oldest); allocated voice moves to the top rank.
// Ranks update one cycle after alloc_i; oldest outputs are combinational from the ranks.
module lru_tracker #(
  parameter int N  = adsr_pkg::NUM_VOICES,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc_i,
  input  logic [IW-1:0] alloc_idx_i,
  input  logic [N-1:0]  releasing_i,
  output logic [IW-1:0] oldest_idx_o,
  output logic [IW-1:0] oldest_rel_idx_o
);
  function automatic logic [N*IW-1:0] init_ranks();
    logic [N*IW-1:0] r;
    r = '0;
    for (int v = 0; v < N; v++) r[v*IW +: IW] = IW'(v);
    return r;
  endfunction

  localparam logic [N*IW-1:0] RANK_RST = init_ranks();

  logic [N*IW-1:0] rank_q, rank_d;
  logic [IW-1:0]   alloc_rank;
  logic [IW-1:0]   best_rank;
  logic            rel_found;

  dffre #(.W(N*IW), .RST_VAL(RANK_RST)) u_rank (
    .clk(clk), .reset(reset), .en_i(1'b1), .d_i(rank_d), .q_o(rank_q)
  );

  always_comb begin
    alloc_rank = '0;
    for (int v = 0; v < N; v++)
      if (IW'(v) == alloc_idx_i) alloc_rank = rank_q[v*IW +: IW];
    rank_d = rank_q;
    if (alloc_i) begin
      for (int v = 0; v < N; v++) begin
        if (IW'(v) == alloc_idx_i)
          rank_d[v*IW +: IW] = IW'(N-1);
        else if (rank_q[v*IW +: IW] > alloc_rank)
          rank_d[v*IW +: IW] = rank_q[v*IW +: IW] - IW'(1);
      end
    end
  end

  // Minimum-rank search restricted to releasing voices.
  always_comb begin
    oldest_idx_o     = '0;
    oldest_rel_idx_o = '0;
    best_rank        = '1;
    rel_found        = 1'b0;
    for (int v = 0; v < N; v++) begin
      if (rank_q[v*IW +: IW] == '0) oldest_idx_o = IW'(v);
      if (releasing_i[v] && (!rel_found || rank_q[v*IW +: IW] < best_rank)) begin
        rel_found        = 1'b1;
        best_rank        = rank_q[v*IW +: IW];
        oldest_rel_idx_o = IW'(v);
      end
    end
  end
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note-to-voice allocator driving adsr_envelope play/kill, note and preset.
// Free voice: 1 cycle, busy-free. Steal: kill at T+1, play at T+2; note_ready low meanwhile.
module voice_allocator #(
  parameter int NUM_VOICES = adsr_pkg::NUM_VOICES,
  parameter int NOTE_W     = adsr_pkg::NOTE_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         note_valid,
  input  logic                         note_on,
  input  logic [NOTE_W-1:0]            note_id,
  input  logic [1:0]                   emotion,
  output logic                         note_ready,
  input  logic [NUM_VOICES-1:0]        env_active,
  output logic [NUM_VOICES-1:0]        play_enable,
  output logic [NUM_VOICES-1:0]        voice_kill,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*32-1:0]     voice_adsr
);
  import adsr_pkg::*;

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [1:0]                   state_raw_q;
  state_t                       state_q, state_d;
  logic [NUM_VOICES-1:0]        play_q, play_d, kill_q, kill_d;
  logic [NUM_VOICES*NOTE_W-1:0] note_q, note_d;
  logic [NUM_VOICES*32-1:0]     adsr_q, adsr_d;
  logic [IW-1:0]                tgt_q, tgt_d;

  logic          accept, alloc, steal;
  logic          match_hit, free_hit;
  logic [IW-1:0] match_idx, free_idx, sel_idx, oldest_idx, oldest_rel_idx;

  dffre #(.W(2), .RST_VAL(2'(S_IDLE))) u_state (
    .clk(clk), .reset(reset), .en_i(1'b1), .d_i(2'(state_d)), .q_o(state_raw_q));
  dffre #(.W(NUM_VOICES)) u_play (
    .clk(clk), .reset(reset), .en_i(1'b1), .d_i(play_d), .q_o(play_q));
  dffre #(.W(NUM_VOICES)) u_kill (
    .clk(clk), .reset(reset), .en_i(1'b1), .d_i(kill_d), .q_o(kill_q));
  dffre #(.W(NUM_VOICES*NOTE_W)) u_note (
    .clk(clk), .reset(reset), .en_i(1'b1), .d_i(note_d), .q_o(note_q));
  dffre #(.W(NUM_VOICES*32)) u_adsr (
    .clk(clk), .reset(reset), .en_i(1'b1), .d_i(adsr_d), .q_o(adsr_q));
  dffre #(.W(IW)) u_tgt (
    .clk(clk), .reset(reset), .en_i(1'b1), .d_i(tgt_d), .q_o(tgt_q));

  lru_tracker #(.N(NUM_VOICES), .IW(IW)) u_lru (
    .clk(clk), .reset(reset), .alloc_i(alloc), .alloc_idx_i(sel_idx),
    .releasing_i(~play_q), .oldest_idx_o(oldest_idx), .oldest_rel_idx_o(oldest_rel_idx)
  );

  assign state_q     = state_t'(state_raw_q);
  assign note_ready  = (state_q == S_IDLE);
  assign accept      = note_valid && note_ready;
  assign play_enable = play_q;
  assign voice_kill  = kill_q;
  assign voice_note  = note_q;
  assign voice_adsr  = adsr_q;

  // Descending scans leave the lowest matching index in place.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int v = NUM_VOICES-1; v >= 0; v--) begin
      if (play_q[v] && note_q[v*NOTE_W +: NOTE_W] == note_id) begin
        match_hit = 1'b1;
        match_idx = IW'(v);
      end
      if (!play_q[v] && !env_active[v]) begin
        free_hit = 1'b1;
        free_idx = IW'(v);
      end
    end
    steal = 1'b1;
    if (match_hit)       sel_idx = match_idx;
    else if (free_hit) begin
      sel_idx = free_idx;
      steal   = 1'b0;
    end
    else if (~play_q != '0) sel_idx = oldest_rel_idx;
    else                    sel_idx = oldest_idx;
  end

  always_comb begin
    state_d = state_q;
    play_d  = play_q;
    kill_d  = '0;
    note_d  = note_q;
    adsr_d  = adsr_q;
    tgt_d   = tgt_q;
    alloc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && note_on) begin
          alloc = 1'b1;
          tgt_d = sel_idx;
          note_d[sel_idx*NOTE_W +: NOTE_W] = note_id;
          adsr_d[sel_idx*32 +: 32]         = preset_lookup(emotion);
          if (steal) begin
            play_d[sel_idx] = 1'b0;
            kill_d[sel_idx] = 1'b1;
            state_d         = S_KILL;
          end else begin
            play_d[sel_idx] = 1'b1;
          end
        end else if (accept && match_hit) begin
          play_d[match_idx] = 1'b0;
        end
      end
      S_KILL: begin
        play_d[tgt_q] = 1'b1;
        state_d       = S_START;
      end
      S_START: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Table-driven bench for voice_allocator: each row is one clock of stimulus and the outputs expected after it.
module tb_voice_allocator;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        note_valid = 1'b0;
  logic        note_on = 1'b0;
  logic [6:0]  note_id = '0;
  logic [1:0]  emotion = '0;
  logic        note_ready;
  logic [3:0]  env_active = '0;
  logic [3:0]  play_enable, voice_kill;
  logic [27:0] voice_note;
  logic [127:0] voice_adsr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        rst, vld, on;
    logic [6:0]  id;
    logic [1:0]  emo;
    logic [3:0]  env;
    logic [3:0]  play, kill;
    logic        rdy;
    int          cv;
    logic [6:0]  note;
    logic [31:0] adsr;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  voice_allocator dut (
    .clk(clk), .reset(reset), .note_valid(note_valid), .note_on(note_on),
    .note_id(note_id), .emotion(emotion), .note_ready(note_ready),
    .env_active(env_active), .play_enable(play_enable), .voice_kill(voice_kill),
    .voice_note(voice_note), .voice_adsr(voice_adsr)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, vld, on, input logic [6:0] id,
                              input logic [1:0] emo, input logic [3:0] env,
                              input logic [3:0] play, kill, input logic rdy,
                              input int cv, input logic [6:0] note, input logic [31:0] adsr);
    vec_t v;
    v.rst = rst; v.vld = vld; v.on = on; v.id = id; v.emo = emo; v.env = env;
    v.play = play; v.kill = kill; v.rdy = rdy; v.cv = cv; v.note = note; v.adsr = adsr;
    return v;
  endfunction

  task automatic cmp(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, got, exp);
    end
  endtask

  task automatic check_out(input int row);
    vec_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL row %0d scoreboard: got empty queue expected an entry", row);
      return;
    end
    e = exp_q.pop_front();
    cmp("play_enable", row, 32'(play_enable), 32'(e.play));
    cmp("voice_kill",  row, 32'(voice_kill),  32'(e.kill));
    cmp("note_ready",  row, 32'(note_ready),  32'(e.rdy));
    if (e.cv >= 0) begin
      cmp("voice_note", row, 32'(voice_note[e.cv*7 +: 7]), 32'(e.note));
      cmp("voice_adsr", row, voice_adsr[e.cv*32 +: 32], e.adsr);
    end
  endtask

  task automatic step(input vec_t v, input int row);
    @(negedge clk);
    reset      = v.rst;
    note_valid = v.vld;
    note_on    = v.on;
    note_id    = v.id;
    emotion    = v.emo;
    env_active = v.env;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_out(row);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single note, retrigger, ignored note-off.
    vecs.push_back(mk(1,0,0, 0,0,4'h0, 4'h0,4'h0,1, 3, 0, 32'h0));
    vecs.push_back(mk(0,1,1,60,1,4'h0, 4'h1,4'h0,1, 0,60, 32'h40108040));
    vecs.push_back(mk(0,0,0, 0,0,4'h1, 4'h1,4'h0,1, 0,60, 32'h40108040));
    vecs.push_back(mk(0,1,1,60,3,4'h1, 4'h0,4'h1,0,-1, 0, 32'h0));
    vecs.push_back(mk(0,0,0, 0,0,4'h1, 4'h1,4'h0,0, 0,60, 32'hFF40A040));
    vecs.push_back(mk(0,0,0, 0,0,4'h1, 4'h1,4'h0,1,-1, 0, 32'h0));
    vecs.push_back(mk(0,1,0,50,0,4'h1, 4'h1,4'h0,1, 0,60, 32'hFF40A040));
    // Releasing voice steal, held requests, oldest-overall steals.
    vecs.push_back(mk(1,0,0, 0,0,4'h0, 4'h0,4'h0,1, 0, 0, 32'h0));
    vecs.push_back(mk(0,1,1,60,0,4'h0, 4'h1,4'h0,1, 0,60, 32'h0402C002));
    vecs.push_back(mk(0,1,1,62,2,4'h1, 4'h3,4'h0,1, 1,62, 32'h02016001));
    vecs.push_back(mk(0,1,1,64,1,4'h3, 4'h7,4'h0,1, 2,64, 32'h40108040));
    vecs.push_back(mk(0,1,1,67,3,4'h7, 4'hF,4'h0,1, 3,67, 32'hFF40A040));
    vecs.push_back(mk(0,1,0,62,0,4'hF, 4'hD,4'h0,1, 1,62, 32'h02016001));
    vecs.push_back(mk(0,1,1,69,0,4'hF, 4'hD,4'h2,0,-1, 0, 32'h0));
    vecs.push_back(mk(0,1,1,80,1,4'hF, 4'hF,4'h0,0, 1,69, 32'h0402C002));
    vecs.push_back(mk(0,1,1,80,1,4'hF, 4'hF,4'h0,1,-1, 0, 32'h0));
    vecs.push_back(mk(0,1,1,80,1,4'hF, 4'hE,4'h1,0,-1, 0, 32'h0));
    vecs.push_back(mk(0,0,0, 0,0,4'hF, 4'hF,4'h0,0, 0,80, 32'h40108040));
    vecs.push_back(mk(0,0,0, 0,0,4'hF, 4'hF,4'h0,1, 1,69, 32'h0402C002));
    vecs.push_back(mk(0,1,1,81,2,4'hF, 4'hB,4'h4,0,-1, 0, 32'h0));
    vecs.push_back(mk(0,0,0, 0,0,4'hF, 4'hF,4'h0,0, 2,81, 32'h02016001));
    vecs.push_back(mk(0,0,0, 0,0,4'hF, 4'hF,4'h0,1,-1, 0, 32'h0));
    // Four held notes, then two oldest-overall steals in LRU order.
    vecs.push_back(mk(1,0,0, 0,0,4'h0, 4'h0,4'h0,1, 1, 0, 32'h0));
    vecs.push_back(mk(0,1,1,60,1,4'h0, 4'h1,4'h0,1, 0,60, 32'h40108040));
    vecs.push_back(mk(0,1,1,62,1,4'h1, 4'h3,4'h0,1, 1,62, 32'h40108040));
    vecs.push_back(mk(0,1,1,64,1,4'h3, 4'h7,4'h0,1, 2,64, 32'h40108040));
    vecs.push_back(mk(0,1,1,67,1,4'h7, 4'hF,4'h0,1, 3,67, 32'h40108040));
    vecs.push_back(mk(0,1,1,72,0,4'hF, 4'hE,4'h1,0,-1, 0, 32'h0));
    vecs.push_back(mk(0,0,0, 0,0,4'hF, 4'hF,4'h0,0, 0,72, 32'h0402C002));
    vecs.push_back(mk(0,0,0, 0,0,4'hF, 4'hF,4'h0,1,-1, 0, 32'h0));
    vecs.push_back(mk(0,1,1,74,3,4'hF, 4'hD,4'h2,0,-1, 0, 32'h0));
    vecs.push_back(mk(0,0,0, 0,0,4'hF, 4'hF,4'h0,0, 1,74, 32'hFF40A040));
    vecs.push_back(mk(0,0,0, 0,0,4'hF, 4'hF,4'h0,1,-1, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Reset during S_KILL aborts the steal; first post-reset cycle accepts a note.
    step(mk(0,1,1,90,2,4'hF, 4'hB,4'h4,0,-1, 0, 32'h0), 100);
    step(mk(1,0,0, 0,0,4'hF, 4'h0,4'h0,1, 2, 0, 32'h0), 101);
    step(mk(0,0,0, 0,0,4'h0, 4'h0,4'h0,1, 0, 0, 32'h0), 102);
    step(mk(0,1,1,61,0,4'h0, 4'h1,4'h0,1, 0,61, 32'h0402C002), 103);
    step(mk(0,0,0, 0,0,4'h1, 4'h1,4'h0,1, 3, 0, 32'h0), 104);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
